clk_gen_seq: RTL

- Start/stop sequencer for the PHY clock divider (clk_f/clk_2f/clk_4f from clk_32f). Runs on clk_32f.
- Holds the divider in reset, releases it, and waits a settle window before declaring the clock tree ready.
- Emits one-cycle clk_32f-domain phase strobes aligned to divided-clock boundaries, so the striping and serialisation logic can cross domains deterministically.
- On stop, shuts the divider down only on a clk_f boundary.

---
 rtl/clk_gen_pkg.sv | 29 ++
 rtl/clk_phase_cnt.sv | 60 ++++++
 rtl/clk_gen_seq.sv | 132 +++++++++++++
 3 files changed

// File: rtl/clk_gen_pkg.sv
// rtl/clk_gen_pkg.sv - shared states and phase decode constants for the PHY clock sequencer
package clk_gen_pkg;

    localparam int PHASE_W = 5;

    // Phase values on the last clk_32f cycle of each divided-clock period.
    localparam logic [PHASE_W-1:0] PH_4F = 5'd7;
    localparam logic [PHASE_W-1:0] PH_2F = 5'd15;
    localparam logic [PHASE_W-1:0] PH_F  = 5'd31;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HOLD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_DRAIN  = 3'd4
    } state_t;

    // Divider is out of reset in these states.
    function automatic logic div_released(input state_t s);
        return (s == ST_SETTLE) || (s == ST_RUN) || (s == ST_DRAIN);
    endfunction

    // Phase strobes are passed to the outside world only in these states.
    function automatic logic strobes_live(input state_t s);
        return (s == ST_RUN) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/clk_phase_cnt.sv
// rtl/clk_phase_cnt.sv - clk_32f phase counter with registered divided-clock boundary strobes
//
// Ports:
//   i_clk_32f  clock
//   i_reset    asynchronous active-low reset
//   i_run      current divider-released flag; phase advances while set
//   i_clr      divider goes (or stays) in reset on this edge; forces phase to 0
//   o_phase    clk_32f cycle index within one clk_f period
//   o_str_4f   phase[2:0] == 7   (ungated)
//   o_str_2f   phase[3:0] == 15  (ungated)
//   o_str_f    phase == 31       (ungated)
module clk_phase_cnt
    import clk_gen_pkg::*;
(
    input  logic               i_clk_32f,
    input  logic               i_reset,
    input  logic               i_run,
    input  logic               i_clr,
    output logic [PHASE_W-1:0] o_phase,
    output logic               o_str_4f,
    output logic               o_str_2f,
    output logic               o_str_f
);

    logic [PHASE_W-1:0] r_phase;
    logic               r_str_4f;
    logic               r_str_2f;
    logic               r_str_f;
    logic [PHASE_W-1:0] w_phase_nxt;

    // i_clr comes from the sequencer's next-state decode so phase drops to 0
    // on the same edge the divider is put back into reset.
    always_comb begin
        w_phase_nxt = '0;
        if (i_run && !i_clr) begin
            w_phase_nxt = r_phase + PHASE_W'(1);
        end
    end

    // Strobes are decoded from the next phase so they line up with o_phase.
    always_ff @(posedge i_clk_32f or negedge i_reset) begin
        if (!i_reset) begin
            r_phase  <= '0;
            r_str_4f <= 1'b0;
            r_str_2f <= 1'b0;
            r_str_f  <= 1'b0;
        end else begin
            r_phase  <= w_phase_nxt;
            r_str_4f <= (w_phase_nxt[2:0] == PH_4F[2:0]);
            r_str_2f <= (w_phase_nxt[3:0] == PH_2F[3:0]);
            r_str_f  <= (w_phase_nxt == PH_F);
        end
    end

    assign o_phase  = r_phase;
    assign o_str_4f = r_str_4f;
    assign o_str_2f = r_str_2f;
    assign o_str_f  = r_str_f;

endmodule

// File: rtl/clk_gen_seq.sv
// rtl/clk_gen_seq.sv - start/stop sequencer for the PHY clock divider with phase strobes
//
// Ports:
//   i_clk_32f    fastest PHY clock, sole clock of this block
//   i_reset      asynchronous active-low reset
//   i_start      level request to bring up the divider (IDLE only)
//   i_stop       level request to shut the divider down
//   o_div_reset  active-low divider reset
//   o_phase      clk_32f cycle index within one clk_f period
//   o_en_4f      strobe on the last clk_32f cycle of each clk_4f period
//   o_en_2f      strobe on the last clk_32f cycle of each clk_2f period
//   o_en_f       strobe on the last clk_32f cycle of each clk_f period
//   o_ready      divided clocks stable and usable
module clk_gen_seq
    import clk_gen_pkg::*;
#(
    parameter int HOLD_CYC   = 4,
    parameter int SETTLE_CYC = 32,
    parameter int CNT_W      = 6
)
(
    input  logic               i_clk_32f,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_stop,
    output logic               o_div_reset,
    output logic [PHASE_W-1:0] o_phase,
    output logic               o_en_4f,
    output logic               o_en_2f,
    output logic               o_en_f,
    output logic               o_ready
);

    // HOLD is entered on the start edge with the counter at 0, so the divider
    // stays in reset for HOLD_CYC further edges before release.
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_div_reset;
    logic             r_ready;
    logic             r_str_gate;
    logic             w_div_reset_nxt;
    logic             w_str_4f;
    logic             w_str_2f;
    logic             w_str_f;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        case (r_state)
            ST_IDLE: begin
                // stop has priority over start
                if (i_start && !i_stop) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (i_stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == HOLD_LAST) begin
                    w_state_nxt = ST_SETTLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                // SETTLE_CYC is a multiple of 32, so RUN starts at phase 0.
                if (i_stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == SETTLE_LAST) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (i_stop) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Shut down only on a clk_f boundary; stop is no longer looked at.
                if (o_phase == PH_F) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_div_reset_nxt = div_released(w_state_nxt);

    always_ff @(posedge i_clk_32f or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_div_reset <= 1'b0;
            r_ready     <= 1'b0;
            r_str_gate  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_div_reset <= w_div_reset_nxt;
            r_ready     <= (w_state_nxt == ST_RUN);
            r_str_gate  <= strobes_live(w_state_nxt);
        end
    end

    clk_phase_cnt u_phase (
        .i_clk_32f (i_clk_32f),
        .i_reset   (i_reset),
        .i_run     (r_div_reset),
        .i_clr     (!w_div_reset_nxt),
        .o_phase   (o_phase),
        .o_str_4f  (w_str_4f),
        .o_str_2f  (w_str_2f),
        .o_str_f   (w_str_f)
    );

    assign o_div_reset = r_div_reset;
    assign o_ready     = r_ready;
    assign o_en_4f     = w_str_4f & r_str_gate;
    assign o_en_2f     = w_str_2f & r_str_gate;
    assign o_en_f      = w_str_f  & r_str_gate;

endmodule
